// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the checksum seed.
package imem_loader_pkg;

  // Loader FSM states; 3-bit encoding shared by the top and any observers.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Running XOR checksum starts from this value at every accepted start.
  localparam logic [7:0] CKSUM_SEED = 8'h00;

endpackage : imem_loader_pkg

// File: rtl/imem_loader_byte_packer.sv
// Packs a stream of accepted bytes little-endian into one instruction word.
// Byte k lands in bits [8k+7:8k]; word_full flags the cycle the last byte
// of the word is accepted.
module byte_packer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_accept,
  input  logic [7:0]   i_byte,
  output logic [N-1:0] o_word,
  output logic         o_word_full
);

  localparam int BPW = N / 8;

  logic [N-1:0] r_word;
  logic [1:0]   r_idx;

  // Shift each accepted byte in from the top so the first byte ends up lowest.
  // NOTE: asynchronous reset is in the sensitivity list so the partial word
  // is dropped the instant rst rises, not on the next clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_accept) begin
      r_word <= {i_byte, r_word[N-1:8]};
      r_idx  <= r_idx + 2'd1;
    end
  end

  assign o_word      = r_word;
  assign o_word_full = i_accept && (r_idx == 2'(BPW - 1));

endmodule : byte_packer

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream, packs it into N-bit
// words, writes them to consecutive word addresses from 0 while holding the
// core, then verifies a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N     = 32,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   word_count,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [N-1:0]  imem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [AW:0]   r_count;
  logic [AW:0]   r_widx;
  logic [7:0]    r_cksum;
  logic          r_err;

  logic          w_start_ok;
  logic [AW:0]   w_count_clamped;
  logic          w_accept;
  logic          w_load_accept;
  logic          w_word_full;
  logic          w_last_word;
  logic          w_packer_clear;
  logic [N-1:0]  w_word;

  assign w_start_ok      = start && (r_state == ST_IDLE);
  assign w_count_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign w_accept        = byte_valid && byte_ready;
  assign w_load_accept   = w_accept && (r_state == ST_LOAD);
  assign w_last_word     = (r_widx + (AW + 1)'(1)) == r_count;
  assign w_packer_clear  = (r_state == ST_WRITE) || w_start_ok;

  byte_packer #(
    .N(N)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_packer_clear),
    .i_accept    (w_load_accept),
    .i_byte      (byte_in),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  // NOTE: the default assignment before the case keeps this purely
  // combinational; a missing branch would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = (w_count_clamped != '0) ? ST_LOAD : ST_DONE;
      ST_LOAD:  if (w_word_full) w_next = ST_WRITE;
      ST_WRITE: w_next = w_last_word ? ST_CHECK : ST_LOAD;
      ST_CHECK: if (w_accept) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b0;
    busy       = (r_state != ST_IDLE);
    done       = 1'b0;
    unique case (r_state)
      ST_LOAD:  begin byte_ready = 1'b1; cpu_hold = 1'b1; end
      ST_WRITE: begin imem_we    = 1'b1; cpu_hold = 1'b1; end
      ST_CHECK: begin byte_ready = 1'b1; cpu_hold = 1'b1; end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Word index, sampled count, running checksum and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_widx  <= '0;
      r_cksum <= CKSUM_SEED;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          r_count <= w_count_clamped;
          r_widx  <= '0;
          r_cksum <= CKSUM_SEED;
          r_err   <= 1'b0;
        end
        ST_LOAD:  if (w_load_accept) r_cksum <= r_cksum ^ byte_in;
        ST_WRITE: r_widx <= r_widx + (AW + 1)'(1);
        ST_CHECK: if (w_accept) r_err <= (byte_in != r_cksum);
        default:  ;
      endcase
    end
  end

  assign imem_addr  = r_widx[AW-1:0];
  assign imem_wdata = w_word;
  assign err        = r_err;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader. Expected writes, error flag
// and handshake timing come from a byte-level model of the load protocol.
module tb_imem_loader;

  localparam int N     = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   word_count;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [N-1:0]  imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } wr_t;

  int          n_checks = 0;
  int          n_errors = 0;
  wr_t         act_q[$];
  int          cyc = 0;
  int          last_we_cyc = -100;
  int          ready_viol = 0;
  int          gap_viol = 0;
  int          hold_viol = 0;
  logic [31:0] fixed_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: records every strobe, checks ready is low and word spacing.
  always @(negedge clk) begin
    cyc++;
    if (!rst && imem_we) begin
      act_q.push_back(wr_t'{imem_addr, imem_wdata});
      if (byte_ready) ready_viol++;
      if (cyc - last_we_cyc < 5) gap_viol++;
      last_we_cyc = cyc;
    end
  end

  // Offer one byte, with optional random idle cycles, until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    int guard;
    while ($urandom_range(99) < stall_pct) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(negedge clk);
      if (!cpu_hold && !done) hold_viol++;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    guard      = 0;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      if (!cpu_hold && !done) hold_viol++;
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 1, 0);
    @(negedge clk);
    if (!cpu_hold && !done) hold_viol++;
    byte_valid = 1'b0;
  endtask

  // One complete load. ck_mode: 0 correct checksum, 1 corrupted, 2 forced value.
  task automatic run_load(input int cnt, input int stall_pct, input int ck_mode,
                          input logic [7:0] ck_forced, input bit poke_start);
    int          eff;
    logic [31:0] w;
    logic [7:0]  bytes[$];
    wr_t         exp_q[$];
    logic [7:0]  ck;
    logic [7:0]  ck_sent;
    bit          exp_err;
    eff = (cnt > DEPTH) ? DEPTH : cnt;
    ck  = 8'h00;
    for (int i = 0; i < eff; i++) begin
      w = (i < fixed_q.size()) ? fixed_q[i] : $urandom;
      exp_q.push_back(wr_t'{AW'(i), w});
      for (int k = 0; k < 4; k++) begin
        bytes.push_back(w[8*k +: 8]);
        ck = ck ^ w[8*k +: 8];
      end
    end
    case (ck_mode)
      0:       ck_sent = ck;
      1:       ck_sent = ck ^ 8'($urandom_range(255, 1));
      default: ck_sent = ck_forced;
    endcase
    exp_err = (ck_sent != ck);

    act_q.delete();
    hold_viol = 0;
    @(negedge clk);
    start      = 1'b1;
    word_count = (AW + 1)'(cnt);
    @(negedge clk);
    start      = 1'b0;
    word_count = (AW + 1)'($urandom);
    check("err_cleared_on_start", err, 0);
    check("busy_after_start", busy, 1);

    if (eff == 0) begin
      check("zero_done", done, 1);
      check("zero_hold", cpu_hold, 0);
      @(negedge clk);
      check("zero_idle_busy", busy, 0);
      check("zero_no_writes", act_q.size(), 0);
      return;
    end

    check("hold_after_start", cpu_hold, 1);
    for (int i = 0; i < bytes.size(); i++) begin
      if (poke_start && i == 1) begin
        start      = 1'b1;
        word_count = (AW + 1)'(1);
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(bytes[i], stall_pct);
    end
    send_byte(ck_sent, stall_pct);

    check("done_pulse", done, 1);
    check("done_hold_low", cpu_hold, 0);
    check("done_err", err, exp_err);
    check("hold_during_load", hold_viol, 0);
    check("write_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("write[%0d]", i), act_q[i], exp_q[i]);
    @(negedge clk);
    check("idle_done_low", done, 0);
    check("idle_busy_low", busy, 0);
    check("err_sticky", err, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    word_count = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    #2;
    check("reset_ctrl", {cpu_hold, busy, done, err, byte_ready, imem_we}, 6'b0);
    check("reset_addr", imem_addr, 0);
    check("reset_wdata", imem_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single word 0x00000013 with matching checksum 0x13.
    fixed_q = '{32'h0000_0013};
    run_load(1, 0, 2, 8'h13, 1'b0);

    // Two known words with a wrong checksum, then a good load clears err.
    fixed_q = '{32'h0050_0093, 32'h00A0_0113};
    run_load(2, 0, 2, 8'h00, 1'b0);
    fixed_q.delete();
    run_load(2, 0, 0, 8'h00, 1'b0);

    // Backpressure with random gaps on byte_valid.
    run_load(6, 50, 0, 8'h00, 1'b0);

    // Reset two bytes into a load: everything drops, no write is issued.
    act_q.delete();
    @(negedge clk);
    start      = 1'b1;
    word_count = (AW + 1)'(2);
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    rst = 1'b1;
    #1;
    check("midrst_ctrl", {cpu_hold, busy, done, err, byte_ready, imem_we}, 6'b0);
    check("midrst_wdata", imem_wdata, 0);
    check("midrst_addr", imem_addr, 0);
    check("midrst_no_write", act_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    run_load(3, 20, 0, 8'h00, 1'b0);

    // Zero count and a start pulse ignored mid-load.
    run_load(0, 0, 0, 8'h00, 1'b0);
    run_load(3, 10, 1, 8'h00, 1'b1);

    // Random mix of counts, stalls and checksum outcomes.
    for (int r = 0; r < 6; r++)
      run_load($urandom_range(5, 1), $urandom_range(60), $urandom_range(1),
               8'h00, 1'($urandom_range(1)));

    // Count above DEPTH is clamped.
    run_load(DEPTH + 1, 0, 0, 8'h00, 1'b0);
    if (act_q.size() > 0) check("clamp_last_addr", act_q[$].addr, DEPTH - 1);

    check("ready_low_in_write", ready_viol, 0);
    check("word_spacing_5cyc", gap_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_imem_loader
